// File: rtl/video_frame_sched.sv
// video_frame_sched: owns the single-port banked frame store and time-shares it
// between VGA scan-out reads (active video) and a 1-bit pixel write stream
// (blanking). Banks swap at end-of-frame once the write bank is complete.
// Optional feature macro: VFS_REPEAT_STATS_EN adds repeat_cnt_o, a saturating
// count of end-of-frame events seen while the write bank was still filling.
module video_frame_sched #(
  parameter int WIDTH       = 200,
  parameter int HEIGHT      = 150,
  parameter int SCALE_LOG2  = 2,
  parameter int H_ACTIVE    = 800,
  parameter int WHOLE_LINE  = 1056,
  parameter int V_ACTIVE    = 600,
  parameter int WHOLE_FRAME = 628,
  parameter int NUM_BANKS   = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wr_valid_i,
  input  logic        wr_data_i,
  input  logic        wr_sof_i,
  output logic        wr_ready_o,
  output logic [3:0]  mem_bank_o,
  output logic [7:0]  mem_x_o,
  output logic [7:0]  mem_y_o,
  output logic        mem_data_o,
  output logic        mem_we_o,
  input  logic        mem_rdata_i,
  output logic        disp_pixel_o,
  output logic        disp_valid_o,
`ifdef VFS_REPEAT_STATS_EN
  output logic [15:0] repeat_cnt_o,
`endif
  output logic        frame_swap_o
);

  localparam int H_W = $clog2(WHOLE_LINE);
  localparam int V_W = $clog2(WHOLE_FRAME);
  localparam logic [H_W-1:0] H_LAST = H_W'(WHOLE_LINE - 1);
  localparam logic [V_W-1:0] V_LAST = V_W'(WHOLE_FRAME - 1);
  localparam logic [7:0]     X_LAST = 8'(WIDTH - 1);
  localparam logic [7:0]     Y_LAST = 8'(HEIGHT - 1);
  localparam logic [3:0]     B_LAST = 4'(NUM_BANKS - 1);

  typedef enum logic {FILL = 1'b0, FULL = 1'b1} state_e;

  state_e         state_q, state_d;
  logic [H_W-1:0] h_q, h_d;
  logic [V_W-1:0] v_q, v_d;
  logic [3:0]     disp_bank_q, disp_bank_d;
  logic [3:0]     wr_bank_q, wr_bank_d;
  logic [7:0]     wx_q, wx_d;
  logic [7:0]     wy_q, wy_d;
  logic [3:0]     mem_bank_q, mem_bank_d;
  logic [7:0]     mem_x_q, mem_x_d;
  logic [7:0]     mem_y_q, mem_y_d;
  logic           mem_data_q, mem_data_d;
  logic           mem_we_q, mem_we_d;
  logic           act_d1_q, act_d1_d;
  logic           disp_valid_q, disp_valid_d;
  logic           swap_q, swap_d;
`ifdef VFS_REPEAT_STATS_EN
  logic [15:0]    rep_q, rep_d;
`endif

  logic active_s;
  logic accept_s;
  logic eof_s;
  logic last_px_s;

  assign active_s  = (h_q < H_W'(H_ACTIVE)) && (v_q < V_W'(V_ACTIVE));
  assign eof_s     = (h_q == H_LAST) && (v_q == V_LAST);
  assign wr_ready_o = (state_q == FILL) && !active_s;
  assign accept_s  = wr_valid_i && wr_ready_o;
  // A start-of-frame beat always lands on (0,0), so it can never complete the bank.
  assign last_px_s = accept_s && !wr_sof_i && (wx_q == X_LAST) && (wy_q == Y_LAST);

  // Next-state: raster counters, port mux, write pointer and bank-swap FSM.
  always_comb begin
    state_d      = state_q;
    h_d          = h_q;
    v_d          = v_q;
    disp_bank_d  = disp_bank_q;
    wr_bank_d    = wr_bank_q;
    wx_d         = wx_q;
    wy_d         = wy_q;
    mem_bank_d   = mem_bank_q;
    mem_x_d      = mem_x_q;
    mem_y_d      = mem_y_q;
    mem_data_d   = mem_data_q;
    mem_we_d     = 1'b0;
    swap_d       = 1'b0;
    act_d1_d     = active_s;
    disp_valid_d = act_d1_q;
`ifdef VFS_REPEAT_STATS_EN
    rep_d        = rep_q;
`endif

    if (h_q == H_LAST) begin
      h_d = '0;
      if (v_q == V_LAST) begin
        v_d = '0;
      end else begin
        v_d = v_q + 1'b1;
      end
    end else begin
      h_d = h_q + 1'b1;
    end

    // Scan-out owns the port in active video; writes only ever get blanking slots.
    if (active_s) begin
      mem_bank_d = disp_bank_q;
      mem_x_d    = 8'(h_q >> SCALE_LOG2);
      mem_y_d    = 8'(v_q >> SCALE_LOG2);
    end else if (accept_s) begin
      mem_bank_d = wr_bank_q;
      mem_x_d    = wr_sof_i ? 8'd0 : wx_q;
      mem_y_d    = wr_sof_i ? 8'd0 : wy_q;
      mem_data_d = wr_data_i;
      mem_we_d   = 1'b1;
    end else begin
      mem_we_d   = 1'b0;
    end

    if (accept_s) begin
      if (wr_sof_i) begin
        wx_d = 8'd1;
        wy_d = 8'd0;
      end else if (wx_q == X_LAST) begin
        wx_d = 8'd0;
        wy_d = (wy_q == Y_LAST) ? 8'd0 : wy_q + 8'd1;
      end else begin
        wx_d = wx_q + 8'd1;
      end
    end else begin
      wx_d = wx_q;
    end

    case (state_q)
      FILL: begin
        if (last_px_s) begin
          state_d = FULL;
        end else begin
          state_d = FILL;
        end
`ifdef VFS_REPEAT_STATS_EN
        if (eof_s && (rep_q != 16'hFFFF)) begin
          rep_d = rep_q + 16'd1;
        end else begin
          rep_d = rep_q;
        end
`endif
      end
      FULL: begin
        if (eof_s) begin
          state_d     = FILL;
          disp_bank_d = wr_bank_q;
          wr_bank_d   = (wr_bank_q == B_LAST) ? 4'd0 : wr_bank_q + 4'd1;
          swap_d      = 1'b1;
        end else begin
          state_d     = FULL;
        end
      end
      default: state_d = FILL;
    endcase
  end

  // State register bank with asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= FILL;
      h_q          <= '0;
      v_q          <= '0;
      disp_bank_q  <= 4'd0;
      wr_bank_q    <= 4'd1;
      wx_q         <= 8'd0;
      wy_q         <= 8'd0;
      mem_bank_q   <= 4'd0;
      mem_x_q      <= 8'd0;
      mem_y_q      <= 8'd0;
      mem_data_q   <= 1'b0;
      mem_we_q     <= 1'b0;
      act_d1_q     <= 1'b0;
      disp_valid_q <= 1'b0;
      swap_q       <= 1'b0;
`ifdef VFS_REPEAT_STATS_EN
      rep_q        <= 16'd0;
`endif
    end else begin
      state_q      <= state_d;
      h_q          <= h_d;
      v_q          <= v_d;
      disp_bank_q  <= disp_bank_d;
      wr_bank_q    <= wr_bank_d;
      wx_q         <= wx_d;
      wy_q         <= wy_d;
      mem_bank_q   <= mem_bank_d;
      mem_x_q      <= mem_x_d;
      mem_y_q      <= mem_y_d;
      mem_data_q   <= mem_data_d;
      mem_we_q     <= mem_we_d;
      act_d1_q     <= act_d1_d;
      disp_valid_q <= disp_valid_d;
      swap_q       <= swap_d;
`ifdef VFS_REPEAT_STATS_EN
      rep_q        <= rep_d;
`endif
    end
  end

  assign mem_bank_o   = mem_bank_q;
  assign mem_x_o      = mem_x_q;
  assign mem_y_o      = mem_y_q;
  assign mem_data_o   = mem_data_q;
  assign mem_we_o     = mem_we_q;
  assign disp_valid_o = disp_valid_q;
  // RAM read data arrives aligned with the two-cycle-delayed active flag.
  assign disp_pixel_o = disp_valid_q & mem_rdata_i;
  assign frame_swap_o = swap_q;
`ifdef VFS_REPEAT_STATS_EN
  assign repeat_cnt_o = rep_q;
`endif

endmodule

// File: tb/tb_video_frame_sched.sv
// Randomized bench for video_frame_sched with a reduced raster so many frames fit.
// The reference model tracks a frame-cycle position and a linear write index.
module tb_video_frame_sched;

  localparam int W = 8, H = 6, S = 1;
  localparam int HA = 16, WL = 24, VA = 12, WF = 16, NB = 4;
  localparam int FRAME = WL * WF;
  localparam int NPIX = W * H;

  logic clk = 1'b0;
  logic rst_n;
  logic wr_valid, wr_data, wr_sof, wr_ready;
  logic [3:0] mem_bank;
  logic [7:0] mem_x, mem_y;
  logic mem_data, mem_we, mem_rdata;
  logic disp_pixel, disp_valid, frame_swap;
`ifdef VFS_REPEAT_STATS_EN
  logic [15:0] repeat_cnt;
`endif

  int n_checks = 0;
  int n_errors = 0;

  video_frame_sched #(
    .WIDTH(W), .HEIGHT(H), .SCALE_LOG2(S), .H_ACTIVE(HA), .WHOLE_LINE(WL),
    .V_ACTIVE(VA), .WHOLE_FRAME(WF), .NUM_BANKS(NB)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .wr_valid_i(wr_valid), .wr_data_i(wr_data), .wr_sof_i(wr_sof),
    .wr_ready_o(wr_ready),
    .mem_bank_o(mem_bank), .mem_x_o(mem_x), .mem_y_o(mem_y),
    .mem_data_o(mem_data), .mem_we_o(mem_we), .mem_rdata_i(mem_rdata),
    .disp_pixel_o(disp_pixel), .disp_valid_o(disp_valid),
`ifdef VFS_REPEAT_STATS_EN
    .repeat_cnt_o(repeat_cnt),
`endif
    .frame_swap_o(frame_swap)
  );

  always #5 clk = ~clk;

  // RAM fixture: registered read, write on mem_we
  bit ram [NB*NPIX];
  function automatic int ram_index(input logic [3:0] b, input logic [7:0] x, input logic [7:0] y);
    return (int'(b) * NPIX + int'(y) * W + int'(x)) % (NB * NPIX);
  endfunction
  always @(posedge clk) begin
    if (mem_we) ram[ram_index(mem_bank, mem_x, mem_y)] <= mem_data;
    mem_rdata <= ram[ram_index(mem_bank, mem_x, mem_y)];
  end

  // Reference model state
  bit store [NB][NPIX];
  int m_pos, m_ptr, m_disp, m_wr, m_rep;
  bit m_full, m_ready;
  int e_bank, e_x, e_y;
  bit e_we, e_data, e_swap, e_dv, e_dp, p1_v, p1_p;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic bit model_ready();
    int h, v;
    h = m_pos % WL;
    v = m_pos / WL;
    return !m_full && !((h < HA) && (v < VA));
  endfunction

  task automatic model_reset();
    m_pos = 0; m_ptr = 0; m_disp = 0; m_wr = 1; m_rep = 0; m_full = 0; m_ready = 0;
    e_bank = 0; e_x = 0; e_y = 0; e_we = 0; e_data = 0; e_swap = 0;
    e_dv = 0; e_dp = 0; p1_v = 0; p1_p = 0;
  endtask

  task automatic model_step(input bit v, input bit d, input bit sof);
    int h, vv, idx;
    bit act, acc, eof;
    h = m_pos % WL;
    vv = m_pos / WL;
    act = (h < HA) && (vv < VA);
    m_ready = !m_full && !act;
    acc = v && m_ready;
    eof = (m_pos == FRAME - 1);
    e_dv = p1_v;
    e_dp = p1_p;
    p1_v = act;
    p1_p = act ? store[m_disp][(vv >> S) * W + (h >> S)] : 1'b0;
    e_swap = m_full && eof;
    if (act) begin
      e_we = 0; e_bank = m_disp; e_x = h >> S; e_y = vv >> S;
    end else if (acc) begin
      idx = sof ? 0 : m_ptr;
      e_we = 1; e_bank = m_wr; e_x = idx % W; e_y = idx / W; e_data = d;
      store[m_wr][idx] = d;
    end else begin
      e_we = 0;
    end
    if (!m_full && eof && m_rep < 65535) m_rep++;
    if (e_swap) begin
      m_full = 0; m_disp = m_wr; m_wr = (m_wr + 1) % NB;
    end
    if (acc) begin
      if (sof) m_ptr = 1;
      else if (m_ptr == NPIX - 1) begin m_ptr = 0; m_full = 1; end
      else m_ptr++;
    end
    m_pos = (m_pos + 1) % FRAME;
  endtask

  // One clock: starts and ends on a falling edge
  task automatic step(input bit v, input bit d, input bit sof);
    wr_valid = v; wr_data = d; wr_sof = sof;
    model_step(v, d, sof);
    #1 check_val("wr_ready", wr_ready, m_ready);
    @(posedge clk);
    #1;
    check_val("mem_we", mem_we, e_we);
    check_val("mem_bank", mem_bank, e_bank);
    check_val("mem_x", mem_x, e_x);
    check_val("mem_y", mem_y, e_y);
    check_val("mem_data", mem_data, e_data);
    check_val("frame_swap", frame_swap, e_swap);
    check_val("disp_valid", disp_valid, e_dv);
    check_val("disp_pixel", disp_pixel, e_dp);
`ifdef VFS_REPEAT_STATS_EN
    check_val("repeat_cnt", repeat_cnt, m_rep);
`endif
    @(negedge clk);
  endtask

  task automatic step_rand();
    step($urandom_range(0, 3) != 0, 1'($urandom), $urandom_range(0, 63) == 0);
  endtask

  task automatic check_all_zero(input string tag);
    check_val({tag, "_outs"},
              {wr_ready, mem_bank, mem_x, mem_y, mem_data, mem_we, disp_pixel, disp_valid, frame_swap},
              32'd0);
`ifdef VFS_REPEAT_STATS_EN
    check_val({tag, "_repeat"}, repeat_cnt, 32'd0);
`endif
  endtask

  initial begin
    int budget, swaps;
    rst_n = 1'b0; wr_valid = 1'b0; wr_data = 1'b0; wr_sof = 1'b0;
    for (int b = 0; b < NB; b++)
      for (int i = 0; i < NPIX; i++) begin
        store[b][i] = 1'b0;
        ram[b * NPIX + i] = 1'b0;
      end
    model_reset();
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst_n = 1'b1;

    // No writes for a full frame: pure scan-out of bank 0
    repeat (FRAME) step(1'b0, 1'b0, 1'b0);

    // Random streaming across many swaps (bank ring wraps)
    repeat (10 * FRAME) step_rand();

    // Finish the current bank, let it swap, then stall one pixel short
    budget = 0;
    while (!m_full && budget < 4 * FRAME) begin step(1'b1, 1'($urandom), 1'b0); budget++; end
    check_val("fill_timeout", budget < 4 * FRAME, 1);
    budget = 0;
    while (m_full && budget < 2 * FRAME) begin step(1'b0, 1'b0, 1'b0); budget++; end
    check_val("swap_timeout", budget < 2 * FRAME, 1);
    budget = 0;
    while (m_ptr != NPIX - 1 && budget < 4 * FRAME) begin step(1'b1, 1'($urandom), 1'b0); budget++; end
    check_val("partial_timeout", budget < 4 * FRAME, 1);
    swaps = 0;
    repeat (2 * FRAME) begin
      step(1'b0, 1'b0, 1'b0);
      if (frame_swap) swaps++;
    end
    check_val("stall_swaps", swaps, 0);

    // Start-of-frame beat resynchronises the torn frame
    budget = 0;
    while (!model_ready() && budget < FRAME) begin step(1'b0, 1'b0, 1'b0); budget++; end
    step(1'b1, 1'b1, 1'b1);
    check_val("sof_we", mem_we, 1);
    check_val("sof_xy", {mem_x, mem_y}, 16'h0000);
    check_val("sof_data", mem_data, 1);
    budget = 0;
    while (!model_ready() && budget < FRAME) begin step(1'b0, 1'b0, 1'b0); budget++; end
    step(1'b1, 1'b0, 1'b0);
    check_val("post_sof_we", mem_we, 1);
    check_val("post_sof_xy", {mem_x, mem_y}, 16'h0100);

    // Asynchronous reset while writing in blanking
    budget = 0;
    while (m_pos != 3 * WL + 20 && budget < 2 * FRAME) begin step(1'b1, 1'($urandom), 1'b0); budget++; end
    rst_n = 1'b0;
    #1 check_all_zero("async_reset");
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    budget = 0;
    while (!e_we && budget < FRAME) begin step(1'b1, 1'($urandom), 1'b0); budget++; end
    check_val("rst_wr_bank", mem_bank, 1);
    check_val("rst_wr_xy", {mem_x, mem_y}, 16'h0000);

    repeat (4 * FRAME) step_rand();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
